// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART byte transmitter among NUM_REQ requesters.
// Grant to send_en takes 2 edges; each requester holds req until its ack (a timed-out one may keep waiting).
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 600000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      timeout_err,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      send_en,
  output logic [DATA_W-1:0]         data_byte,
  input  logic                      tx_done
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RELEASE} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     ptr, ptr_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [NUM_REQ-1:0]  ack_nxt;
  logic                timeout_nxt;
  logic                busy_nxt;
  logic [ID_W-1:0]     grant_nxt;
  logic                send_nxt;
  logic [DATA_W-1:0]   data_nxt;

  logic [DATA_W-1:0]   req_bytes [NUM_REQ];
  logic                found;
  logic [ID_W-1:0]     sel;
  logic [ID_W-1:0]     cand;
  logic [ID_W-1:0]     next_id;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Scan ptr, ptr+1, ... with wrap at NUM_REQ; first set req wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
      cand = (cand == ID_LAST) ? '0 : cand + ID_W'(1);
    end
  end

  assign next_id = (grant_id == ID_LAST) ? '0 : grant_id + ID_W'(1);

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    ack_nxt     = '0;
    timeout_nxt = 1'b0;
    busy_nxt    = busy;
    grant_nxt   = grant_id;
    send_nxt    = 1'b0;
    data_nxt    = data_byte;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = sel;
          data_nxt  = req_bytes[sel];
          busy_nxt  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        send_nxt  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        cnt_nxt = cnt + CNT_W'(1);
        // A tx_done seen while send_en is still high belongs to an earlier frame.
        if (tx_done && !send_en) begin
          ack_nxt[grant_id] = 1'b1;
          ptr_nxt           = next_id;
          state_nxt         = RELEASE;
        end else if (cnt == CNT_LAST) begin
          timeout_nxt = 1'b1;
          ptr_nxt     = next_id;
          state_nxt   = RELEASE;
        end
      end
      RELEASE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      ack         <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      grant_id    <= '0;
      send_en     <= 1'b0;
      data_byte   <= '0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      cnt         <= cnt_nxt;
      ack         <= ack_nxt;
      timeout_err <= timeout_nxt;
      busy        <= busy_nxt;
      grant_id    <= grant_nxt;
      send_en     <= send_nxt;
      data_byte   <= data_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level timeline model checked every cycle,
// plus directed scenarios with literal expectations and a serial frame receiver.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int TIMEOUT  = 50;
  localparam int BIT_CYC  = 4;
  localparam int CLK_HALF = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0;
  logic [7:0]  rd [4];
  logic [31:0] req_data;
  logic        tx_done = 1'b0;
  logic [3:0]  ack;
  logic        timeout_err;
  logic        busy;
  logic [1:0]  grant_id;
  logic        send_en;
  logic [7:0]  data_byte;

  assign req_data = {rd[3], rd[2], rd[1], rd[0]};

  always #CLK_HALF clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(2), .DATA_W(8), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack), .timeout_err(timeout_err), .busy(busy), .grant_id(grant_id),
    .send_en(send_en), .data_byte(data_byte), .tx_done(tx_done)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_send = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a transfer is a timeline counted in edges since its grant edge (phase 0).
  // send_en follows phase 1; tx_done counts from phase 3; timeout fires at phase TIMEOUT+1.
  bit         model_on = 1'b0;
  int         m_phase  = -1;
  bit         m_done   = 1'b0;
  int         m_ptr    = 0;
  logic       exp_send = 1'b0;
  logic [3:0] exp_ack  = 4'b0;
  logic       exp_to   = 1'b0;
  logic       exp_busy = 1'b0;
  logic [1:0] exp_gid  = 2'b0;
  logic [7:0] exp_data = 8'b0;

  initial forever begin
    @(posedge clk);
    exp_send = 1'b0;
    exp_ack  = 4'b0;
    exp_to   = 1'b0;
    if (!rst_n) begin
      model_on = 1'b1;
      m_phase  = -1;
      m_done   = 1'b0;
      m_ptr    = 0;
      exp_busy = 1'b0;
      exp_gid  = 2'b0;
      exp_data = 8'b0;
    end else if (model_on) begin
      if (m_done) begin
        m_done   = 1'b0;
        m_phase  = -1;
        exp_busy = 1'b0;
      end else if (m_phase < 0) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          int c;
          c = (m_ptr + i) % NUM_REQ;
          if (m_phase < 0 && req[c[1:0]]) begin
            m_phase  = 0;
            exp_gid  = c[1:0];
            exp_data = rd[c[1:0]];
            exp_busy = 1'b1;
          end
        end
      end else begin
        m_phase++;
        if (m_phase == 1) begin
          exp_send = 1'b1;
        end else if (tx_done && m_phase >= 3) begin
          exp_ack[exp_gid] = 1'b1;
          m_done = 1'b1;
          m_ptr  = (int'(exp_gid) + 1) % NUM_REQ;
        end else if (m_phase == TIMEOUT + 1) begin
          exp_to = 1'b1;
          m_done = 1'b1;
          m_ptr  = (int'(exp_gid) + 1) % NUM_REQ;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      chk("cmp_send_en", send_en, exp_send);
      chk("cmp_ack", ack, exp_ack);
      chk("cmp_timeout_err", timeout_err, exp_to);
      chk("cmp_busy", busy, exp_busy);
      chk("cmp_grant_id", grant_id, exp_gid);
      chk("cmp_data_byte", data_byte, exp_data);
      if (send_en === 1'b1) n_send++;
    end
  end

  // Serial line driven by the bench's byte transmitter, decoded at mid-bit.
  logic       tx_line = 1'b1;
  logic [7:0] rx_byte = 8'h0;
  logic       rx_start = 1'b1;
  logic       rx_stop = 1'b0;
  int         rx_cnt = 0;

  initial forever begin
    @(negedge tx_line);
    #(BIT_CYC*CLK_HALF);
    rx_start = tx_line;
    for (int i = 0; i < 8; i++) begin
      #(BIT_CYC*2*CLK_HALF);
      rx_byte[i] = tx_line;
    end
    #(BIT_CYC*2*CLK_HALF);
    rx_stop = tx_line;
    rx_cnt++;
  end

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = 4'b0;
    tx_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_send();
    int n;
    n = 0;
    while (send_en !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("send_en_seen", send_en, 1);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  // Serve one transfer: tx_done raised dly negedges after send_en is seen.
  task automatic serve(input int dly, output int gid, output logic [7:0] b);
    wait_send();
    gid = int'(grant_id);
    b   = data_byte;
    repeat (dly) @(negedge clk);
    pulse_done();
    chk("serve_ack", ack, 32'd1 << gid);
    req[gid[1:0]] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         g;
    int         n;
    int         s0;
    int         r0;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) rd[i] = 8'h0;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_send_en", send_en, 0);
    chk("rst_ack", ack, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_data_byte", data_byte, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single request, send_en two edges after req is sampled
    s0 = n_send;
    rd[0] = 8'h55;
    req   = 4'b0001;
    @(negedge clk);
    chk("t1_busy_e0", busy, 1);
    chk("t1_send_e0", send_en, 0);
    @(negedge clk);
    chk("t1_send_e1", send_en, 1);
    chk("t1_data_e1", data_byte, 8'h55);
    chk("t1_grant_e1", grant_id, 0);
    @(negedge clk);
    chk("t1_send_e2", send_en, 0);
    repeat (29) @(negedge clk);
    pulse_done();
    chk("t1_ack", ack, 4'b0001);
    chk("t1_busy_at_ack", busy, 1);
    req = 4'b0;
    @(negedge clk);
    chk("t1_ack_clear", ack, 0);
    chk("t1_busy_fall", busy, 0);
    repeat (4) @(negedge clk);
    chk("t1_send_count", n_send - s0, 1);

    // 2: all four at once, then rotation from ptr=2
    do_reset();
    rd[0] = 8'h11; rd[1] = 8'h22; rd[2] = 8'h33; rd[3] = 8'h44;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      serve(20, g, b);
      chk($sformatf("t2_order%0d", i), g, i);
      chk($sformatf("t2_byte%0d", i), b, 32'h11 * (i + 1));
    end
    do_reset();
    req = 4'b0011;
    serve(5, g, b);
    chk("t2b_first", g, 0);
    serve(5, g, b);
    chk("t2b_second", g, 1);
    req = req | 4'b1001;
    serve(5, g, b);
    chk("t2b_req3_first", g, 3);
    serve(5, g, b);
    chk("t2b_req0_last", g, 0);

    // 3: fairness, req0 and req2 re-raised after every ack
    do_reset();
    rd[0] = 8'hA0; rd[2] = 8'hC2;
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      serve(10, g, b);
      chk($sformatf("t3_grant%0d", i), g, (i % 2) * 2);
      @(negedge clk);
      req[g[1:0]] = 1'b1;
    end
    req = 4'b0;

    // 4: watchdog timeout, then the next pending requester is granted
    do_reset();
    rd[1] = 8'h61; rd[3] = 8'h63;
    req = 4'b1010;
    wait_send();
    chk("t4_grant", grant_id, 1);
    n = 0;
    while (timeout_err !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_timeout_delay", n, TIMEOUT);
    chk("t4_no_ack", ack, 0);
    @(negedge clk);
    chk("t4_timeout_one_pulse", timeout_err, 0);
    serve(10, g, b);
    chk("t4_next_grant", g, 3);
    chk("t4_next_byte", b, 8'h63);
    serve(10, g, b);
    chk("t4_retry_grant", g, 1);

    // 5a: stale tx_done during send_en; req and data dropped mid-transfer
    do_reset();
    rd[0] = 8'h5A;
    req = 4'b0001;
    wait_send();
    tx_done = 1'b1;
    rd[0] = 8'hFF;
    req = 4'b0;
    @(negedge clk);
    tx_done = 1'b0;
    chk("t5a_stale_ack", ack, 0);
    chk("t5a_still_busy", busy, 1);
    chk("t5a_data_stable", data_byte, 8'h5A);
    repeat (10) @(negedge clk);
    pulse_done();
    chk("t5a_real_ack", ack, 4'b0001);
    chk("t5a_data_end", data_byte, 8'h5A);

    // 5b: tx_done on the timeout edge wins
    do_reset();
    rd[2] = 8'h3C;
    req = 4'b0100;
    serve(TIMEOUT - 1, g, b);
    chk("t5b_grant", g, 2);
    chk("t5b_no_timeout", timeout_err, 0);

    // 6: reset mid-WAIT, then a real serial frame
    do_reset();
    rd[2] = 8'h77;
    req = 4'b0100;
    wait_send();
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    req = 4'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_rst_send_en", send_en, 0);
    chk("t6_rst_ack", ack, 0);
    chk("t6_rst_timeout", timeout_err, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_grant", grant_id, 0);
    chk("t6_rst_data", data_byte, 0);
    repeat (5) @(negedge clk);
    chk("t6_no_late_ack", ack, 0);
    r0 = rx_cnt;
    rd[1] = 8'hA5;
    req = 4'b0010;
    wait_send();
    chk("t6_grant", grant_id, 1);
    b = data_byte;
    tx_line = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tx_line = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    tx_line = 1'b1;
    repeat (BIT_CYC) @(negedge clk);
    pulse_done();
    chk("t6_ack", ack, 4'b0010);
    req = 4'b0;
    repeat (3) @(negedge clk);
    chk("t6_frame_count", rx_cnt - r0, 1);
    chk("t6_frame_start", rx_start, 0);
    chk("t6_frame_byte", rx_byte, 8'hA5);
    chk("t6_frame_stop", rx_stop, 1);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART byte transmitter between NUM_REQ requesters (key handlers, status reporters, etc.).
- Grants one requester at a time and latches its byte.
- Issues a single send_en pulse to the transmitter, then waits for tx_done, or for a watchdog timeout.
- Returns a one-cycle ack to the served requester and rotates priority.

Parameters:
- NUM_REQ, 4, number of requesters.
- ID_W, 2, width of grant_id; must hold NUM_REQ-1.
- DATA_W, 8, byte width.
- TIMEOUT_CYC, 600000, max clk cycles to wait for tx_done after send_en (default exceeds one 10-bit frame at 9600 baud / 50 MHz).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  NUM_REQ  level request per requester; held until its ack.
- req_data  input  NUM_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W].
- ack  output  NUM_REQ  one-cycle pulse when requester's byte is finished.
- timeout_err  output  1  one-cycle pulse when a transfer is aborted by the watchdog.
- busy  output  1  high whenever the state is not IDLE.
- grant_id  output  ID_W  index of the requester currently or last served.
- send_en  output  1  one-cycle start pulse to the byte transmitter.
- data_byte  output  DATA_W  byte to transmit; stable from send_en until the transfer ends.
- tx_done  input  1  one-cycle completion pulse from the byte transmitter.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-low: rst_n is sampled low on a rising edge of clk.
- Reset values:
  - send_en=0, ack=0, timeout_err=0, busy=0, grant_id=0, data_byte=0, state=IDLE.
  - Priority pointer ptr=0, timeout counter=0.
- Registered outputs: all outputs are registered; no combinational input-to-output paths.
- States: IDLE, LOAD, WAIT, RELEASE.
- IDLE:
  - If any req bit is set at edge E0, select the first set bit scanning ptr, ptr+1, ... mod NUM_REQ.
  - At E0: grant_id<=sel, data_byte<=req_data[sel], busy<=1, state->LOAD.
  - With no req, stay in IDLE.
- LOAD:
  - At E1: send_en<=1, counter<=0, state->WAIT.
  - send_en is high for exactly the cycle between E1 and E2. Request-to-start latency is therefore 2 edges.
- WAIT:
  - send_en<=0 on the first WAIT edge. The counter increments every WAIT cycle.
  - tx_done sampled while send_en is high is stale and ignored.
  - tx_done=1 on a later edge: ack[grant_id]<=1, ptr<=(grant_id+1) mod NUM_REQ, state->RELEASE.
  - Counter reaches TIMEOUT_CYC-1 without tx_done: timeout_err<=1, no ack, ptr advances identically, state->RELEASE.
  - tx_done and timeout on the same edge: tx_done wins; ack is issued, no timeout_err.
- RELEASE:
  - One cycle. ack/timeout_err are cleared, busy<=0, state->IDLE.
  - This gives the requester one cycle to drop req, so the same req is not re-granted from a stale level.
- Requester behaviour during a transfer:
  - req dropped during LOAD/WAIT: the transfer still completes and ack still pulses. Requesters must ignore unexpected acks.
  - req and req_data changes during LOAD/WAIT do not affect data_byte.
- tx_done outside WAIT is ignored.
- Fairness: after serving requester i, requester i has the lowest priority. Every continuously asserted req is served within NUM_REQ transfers.
- Reset mid-operation:
  - All outputs and state return to reset values on the next edge; no ack or timeout_err is issued.
  - The transmitter shares rst_n, so no partial frame continues.
- Minimum back-to-back spacing: 4 edges plus transmitter time per byte.

Test Plan:
1. Single request: req=4'b0001, req_data byte0=0x55; stub returns tx_done 100 cycles after send_en. Required:
   - send_en pulses exactly once, 2 edges after req sampled, with data_byte=0x55 and grant_id=0.
   - ack[0] pulses one cycle on the edge after tx_done.
   - busy falls one edge later.
2. All four requests together, bytes 0x11,0x22,0x33,0x44, each held until its ack. Required:
   - Served in order 0,1,2,3; four send_en pulses with matching data_byte.
   - Then re-raise req0 and req3 after serving only 0,1 in a fresh run (ptr=2): req3 is served before req0.
3. Fairness: req0 re-asserted immediately after every ack, req2 held. Required: grants alternate 0,2,0,2 over 4 transfers.
4. Timeout: TIMEOUT_CYC=50, no tx_done. Required:
   - timeout_err pulses once, 50 cycles after send_en; ack stays 0.
   - The next pending requester is granted.
5. Edge events:
   - tx_done asserted during the send_en cycle is ignored; the transfer continues to the real tx_done.
   - tx_done coinciding with the timeout edge gives ack=1 and timeout_err=0.
6. Reset mid-WAIT: rst_n low for one edge. Required:
   - All outputs 0 and grant_id=0 on the next edge, and no ack.
   - A following req1 with byte 0xA5 and a real byte transmitter produces a correct 10-bit frame on the serial line.
